// File: rtl/irq_event_arb.sv
// -----------------------------------------------------------------------------
// irq_event_arb
//
// Edge-detects an IRQ vector and turns every rising edge into an event word.
// Events are latched in a pending vector and granted round-robin into a
// single valid/ready output register. A second edge on a line whose earlier
// edge has not been granted yet is dropped and flagged on the sticky OVF bit.
//
// Ports
//   CLK        in   1        single clock, rising edge
//   RESET      in   1        synchronous active-high reset
//   IRQ        in   IRQ_CNT  IRQ vector from the upstream IRQ register block
//   EN         in   1        1 = grants allowed (edges are always latched)
//   EVT_VALID  out  1        event word valid
//   EVT_NUM    out  NUM_W    index of the IRQ line that fired
//   EVT_READY  in   1        downstream accepts the event
//   OVF        out  1        sticky overflow flag
//   OVF_CLR    in   1        clears OVF (a same-edge overflow wins)
// -----------------------------------------------------------------------------
module irq_event_arb #(
  parameter int IRQ_CNT = 240,
  parameter int NUM_W   = $clog2(IRQ_CNT)
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [IRQ_CNT-1:0] IRQ,
  input  logic               EN,
  output logic               EVT_VALID,
  output logic [NUM_W-1:0]   EVT_NUM,
  input  logic               EVT_READY,
  output logic               OVF,
  input  logic               OVF_CLR
);

  // Lowest set bit of a vector; MSB of the result is the "found" flag.
  function automatic logic [NUM_W:0] lowest_set(input logic [IRQ_CNT-1:0] vec);
    logic [NUM_W:0] res;
    res = '0;
    // Scan downwards so the last hit is the lowest index.
    for (int i = IRQ_CNT - 1; i >= 0; i--) begin
      res = vec[i] ? {1'b1, NUM_W'(i)} : res;
    end
    return res;
  endfunction

  logic [IRQ_CNT-1:0] r_irq_q;
  logic [IRQ_CNT-1:0] r_pending;
  logic               r_evt_valid;
  logic [NUM_W-1:0]   r_evt_num;
  logic               r_ovf;
  logic [NUM_W-1:0]   r_last_grant;

  logic [IRQ_CNT-1:0] w_rise;
  logic [IRQ_CNT-1:0] w_above_mask;
  logic [IRQ_CNT-1:0] w_clr;
  logic [NUM_W:0]     w_hi;
  logic [NUM_W:0]     w_lo;
  logic [NUM_W-1:0]   w_grant_idx;
  logic               w_free;
  logic               w_grant_vld;
  logic               w_ovf_set;

  assign w_rise = IRQ & ~r_irq_q;

  // The output register can take a new word when empty or being drained now.
  assign w_free      = ~r_evt_valid | EVT_READY;
  assign w_grant_vld = w_free & EN & (|r_pending);

  // Mask of line indices strictly above the last grant (first search region).
  always_comb begin
    w_above_mask = '0;
    for (int i = 0; i < IRQ_CNT; i++) begin
      w_above_mask[i] = (NUM_W'(i) > r_last_grant);
    end
  end

  // Round-robin: lowest pending above last_grant, otherwise wrap to the
  // lowest pending overall (everything pending is then at or below it).
  assign w_hi        = lowest_set(r_pending & w_above_mask);
  assign w_lo        = lowest_set(r_pending);
  assign w_grant_idx = w_hi[NUM_W] ? w_hi[NUM_W-1:0] : w_lo[NUM_W-1:0];

  // One-hot clear of the pending bit being granted this edge.
  always_comb begin
    w_clr = '0;
    for (int i = 0; i < IRQ_CNT; i++) begin
      w_clr[i] = w_grant_vld & (w_grant_idx == NUM_W'(i));
    end
  end

  // A rise on a line that stays pending would be lost; a rise on the line
  // being cleared simply re-arms it.
  assign w_ovf_set = |(w_rise & r_pending & ~w_clr);

  // Edge-detect history; loaded during reset so held-high lines stay silent.
  always_ff @(posedge CLK) begin
    r_irq_q <= IRQ;
  end

  // Pending vector: set wins over the grant clear.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_rise;
    end
  end

  // Output register, held under backpressure, plus round-robin pointer.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_evt_valid  <= 1'b0;
      r_evt_num    <= '0;
      r_last_grant <= NUM_W'(IRQ_CNT - 1);
    end else if (w_grant_vld) begin
      r_evt_valid  <= 1'b1;
      r_evt_num    <= w_grant_idx;
      r_last_grant <= w_grant_idx;
    end else if (w_free) begin
      r_evt_valid  <= 1'b0;
    end else begin
      r_evt_valid  <= r_evt_valid;
    end
  end

  // Sticky overflow flag; a new overflow beats a clear on the same edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf <= 1'b1;
    end else if (OVF_CLR) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= r_ovf;
    end
  end

  assign EVT_VALID = r_evt_valid;
  assign EVT_NUM   = r_evt_num;
  assign OVF       = r_ovf;

endmodule
